// File: rtl/exception_ctrl_pkg.sv
// Shared types and constants for the exception controller.
// State codes double as the MRS "state" read value.
package exc_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HANDLER = 2'd1,
      ST_HALT    = 2'd2
   } state_e;

   localparam logic [3:0] ESR_NONE     = 4'd0;
   localparam logic [3:0] ESR_IRQ      = 4'd1;
   localparam logic [3:0] ESR_INVOP    = 4'd2;
   localparam logic [3:0] ESR_BAD_ERET = 4'd3;

   localparam logic [1:0] SEL_ELR   = 2'b00;
   localparam logic [1:0] SEL_ESR   = 2'b01;
   localparam logic [1:0] SEL_ERR   = 2'b10;
   localparam logic [1:0] SEL_STATE = 2'b11;

endpackage

// File: rtl/exception_ctrl_irq_sync.sv
// Two-flop synchronizer for the external interrupt line.
// Synchronous active-high reset clears both stages.
module irq_sync (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt controller: owns ELR/ESR/ERR, redirects to the
// vector on faults, misplaced ERETs and interrupts, and serves MRS reads.
module exception_ctrl
   import exc_pkg::*;
#(
   parameter int             DW         = 64,
   parameter logic [DW-1:0]  EXC_VECTOR = 64'h0000_0000_0000_00D8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] pc_i,
   input  logic [3:0]    estatus_i,
   input  logic          eret_i,
   input  logic          ext_irq_i,
   input  logic [1:0]    sysreg_sel_i,
   output logic          exc_o,
   output logic [DW-1:0] exc_vector_o,
   output logic          eret_taken_o,
   output logic [DW-1:0] err_o,
   output logic          in_handler_o,
   output logic          halt_o,
   output logic          irq_ack_o,
   output logic [DW-1:0] sysreg_rdata_o
);

   state_e        state_q, state_d;
   logic [DW-1:0] elr_q, elr_d;
   logic [3:0]    esr_q, esr_d;
   logic [DW-1:0] err_q, err_d;
   logic          ack_q, ack_d;
   logic          irq_s;
   logic [DW-1:0] pc_plus4;

   irq_sync u_irq_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (ext_irq_i),
      .q_o   (irq_s)
   );

   assign pc_plus4 = pc_i + DW'(4);

   always_comb begin
      state_d      = state_q;
      elr_d        = elr_q;
      esr_d        = esr_q;
      err_d        = err_q;
      ack_d        = 1'b0;
      exc_o        = 1'b0;
      eret_taken_o = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (estatus_i != ESR_NONE) begin
               exc_o   = 1'b1;
               elr_d   = pc_i;
               esr_d   = estatus_i;
               err_d   = pc_plus4;
               state_d = ST_HANDLER;
            end else if (eret_i) begin
               exc_o   = 1'b1;
               elr_d   = pc_i;
               esr_d   = ESR_BAD_ERET;
               err_d   = pc_plus4;
               state_d = ST_HANDLER;
            end else if (irq_s) begin
               // Suppressed instruction is re-executed on return.
               exc_o   = 1'b1;
               elr_d   = pc_i;
               esr_d   = ESR_IRQ;
               err_d   = pc_i;
               ack_d   = 1'b1;
               state_d = ST_HANDLER;
            end
         end
         ST_HANDLER: begin
            if (estatus_i != ESR_NONE) begin
               state_d = ST_HALT;
            end else if (eret_i) begin
               eret_taken_o = 1'b1;
               state_d      = ST_RUN;
            end
         end
         ST_HALT: ;
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         elr_q   <= '0;
         esr_q   <= ESR_NONE;
         err_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         elr_q   <= elr_d;
         esr_q   <= esr_d;
         err_q   <= err_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      sysreg_rdata_o = '0;
      unique case (sysreg_sel_i)
         SEL_ELR:   sysreg_rdata_o = elr_q;
         SEL_ESR:   sysreg_rdata_o = {{(DW-4){1'b0}}, esr_q};
         SEL_ERR:   sysreg_rdata_o = err_q;
         SEL_STATE: sysreg_rdata_o = {{(DW-2){1'b0}}, state_q};
         default:   sysreg_rdata_o = '0;
      endcase
   end

   assign exc_vector_o = EXC_VECTOR;
   assign err_o        = err_q;
   assign in_handler_o = (state_q == ST_HANDLER);
   assign halt_o       = (state_q == ST_HALT);
   assign irq_ack_o    = ack_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed table, then
// randomized traffic against a rule-level reference model.
module tb_exception_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] pc_i;
   logic [3:0]  estatus_i;
   logic        eret_i;
   logic        ext_irq_i;
   logic [1:0]  sysreg_sel_i;
   logic        exc_o;
   logic [63:0] exc_vector_o;
   logic        eret_taken_o;
   logic [63:0] err_o;
   logic        in_handler_o;
   logic        halt_o;
   logic        irq_ack_o;
   logic [63:0] sysreg_rdata_o;

   exception_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .pc_i           (pc_i),
      .estatus_i      (estatus_i),
      .eret_i         (eret_i),
      .ext_irq_i      (ext_irq_i),
      .sysreg_sel_i   (sysreg_sel_i),
      .exc_o          (exc_o),
      .exc_vector_o   (exc_vector_o),
      .eret_taken_o   (eret_taken_o),
      .err_o          (err_o),
      .in_handler_o   (in_handler_o),
      .halt_o         (halt_o),
      .irq_ack_o      (irq_ack_o),
      .sysreg_rdata_o (sysreg_rdata_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [63:0] pc;
      logic [3:0]  es;
      logic        er;
      logic        irq;
      logic [1:0]  sel;
      logic        exc;
      logic        ert;
      logic        hnd;
      logic        hlt;
      logic        ack;
      logic [63:0] rd;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // reference model: mode 0=RUN 1=HANDLER 2=HALT
   int          m_mode = 0;
   logic [63:0] m_elr = '0;
   logic [63:0] m_err = '0;
   logic [3:0]  m_esr = '0;
   logic        m_ack = 1'b0;
   bit          hist[$];

   logic        e_exc, e_ert, e_hnd, e_hlt, e_ack;
   logic [63:0] e_rd, e_err;
   logic        a_exc, a_ert, a_hnd, a_hlt, a_ack;
   logic [63:0] a_rd, a_err;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t v(
      input logic rst, input logic [63:0] pc, input logic [3:0] es,
      input logic er, input logic irq, input logic [1:0] sel,
      input logic exc, input logic ert, input logic hnd,
      input logic hlt, input logic ack, input logic [63:0] rd);
      vec_t r;
      r.rst = rst; r.pc = pc; r.es = es; r.er = er; r.irq = irq;
      r.sel = sel; r.exc = exc; r.ert = ert; r.hnd = hnd;
      r.hlt = hlt; r.ack = ack; r.rd = rd;
      return r;
   endfunction

   task automatic step(input logic rst, input logic [63:0] pc,
                       input logic [3:0] es, input logic er,
                       input logic irq, input logic [1:0] sel);
      logic [3:0]  cause;
      logic [63:0] ret;
      logic        irq_s;
      logic        took_irq;
      @(negedge clk);
      reset = rst; pc_i = pc; estatus_i = es;
      eret_i = er; ext_irq_i = irq; sysreg_sel_i = sel;
      #1;
      // synchronized request = line value two edges ago
      irq_s    = hist[0];
      cause    = 4'd0;
      ret      = pc + 64'd4;
      took_irq = 1'b0;
      if (es != 4'd0) cause = es;
      else if (er) cause = 4'd3;
      else if (irq_s) begin
         cause = 4'd1; ret = pc; took_irq = 1'b1;
      end
      e_exc = (m_mode == 0) && (cause != 4'd0);
      e_ert = (m_mode == 1) && (es == 4'd0) && er;
      e_hnd = (m_mode == 1);
      e_hlt = (m_mode == 2);
      e_ack = m_ack;
      e_err = m_err;
      case (sel)
         2'd0:    e_rd = m_elr;
         2'd1:    e_rd = {60'd0, m_esr};
         2'd2:    e_rd = m_err;
         default: e_rd = 64'(m_mode);
      endcase
      a_exc = exc_o; a_ert = eret_taken_o; a_hnd = in_handler_o;
      a_hlt = halt_o; a_ack = irq_ack_o; a_rd = sysreg_rdata_o;
      a_err = err_o;
      @(posedge clk);
      if (rst) begin
         m_mode = 0; m_elr = '0; m_esr = '0; m_err = '0; m_ack = 1'b0;
         hist = '{1'b0, 1'b0};
      end else begin
         m_ack = e_exc && took_irq;
         if (e_exc) begin
            m_elr = pc; m_esr = cause; m_err = ret; m_mode = 1;
         end else if (m_mode == 1 && es != 4'd0) m_mode = 2;
         else if (e_ert) m_mode = 0;
         void'(hist.pop_front());
         hist.push_back(irq);
      end
   endtask

   vec_t tbl[$];

   initial begin
      logic        ext;
      logic [63:0] rpc;
      logic [3:0]  res;
      hist = '{1'b0, 1'b0};
      reset = 1'b1; pc_i = '0; estatus_i = '0; eret_i = 1'b0;
      ext_irq_i = 1'b0; sysreg_sel_i = '0;
      step(1, 0, 0, 0, 0, 3);
      step(1, 0, 0, 0, 0, 3);

      // invalid opcode and return
      tbl.push_back(v(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 'h40, 2, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 'h44, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h40));
      tbl.push_back(v(0, 'h44, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2));
      tbl.push_back(v(0, 'h44, 0, 0, 0, 2, 0, 0, 1, 0, 0, 'h44));
      tbl.push_back(v(0, 'h48, 0, 1, 0, 2, 0, 1, 1, 0, 0, 'h44));
      tbl.push_back(v(0, 'h44, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
      // interrupt latency, ack pulse, masked second request
      tbl.push_back(v(0, 'h100, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 'h100, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 'h100, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 'h104, 0, 0, 1, 1, 0, 0, 1, 0, 1, 1));
      tbl.push_back(v(0, 'h104, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h100));
      tbl.push_back(v(0, 'h104, 0, 0, 0, 2, 0, 0, 1, 0, 0, 'h100));
      tbl.push_back(v(0, 'h104, 0, 0, 1, 3, 0, 0, 1, 0, 0, 1));
      tbl.push_back(v(0, 'h104, 0, 0, 1, 3, 0, 0, 1, 0, 0, 1));
      tbl.push_back(v(0, 'h104, 0, 0, 1, 3, 0, 0, 1, 0, 0, 1));
      tbl.push_back(v(0, 'h108, 0, 1, 0, 3, 0, 1, 1, 0, 0, 1));
      tbl.push_back(v(0, 'h200, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 'h204, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1));
      tbl.push_back(v(0, 'h204, 0, 1, 0, 2, 0, 1, 1, 0, 0, 'h200));
      tbl.push_back(v(0, 'h200, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
      // fault and irq together: fault wins, irq taken after ERET
      tbl.push_back(v(0, 'h300, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 'h300, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 'h300, 2, 0, 1, 3, 1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 'h304, 0, 0, 1, 1, 0, 0, 1, 0, 0, 2));
      tbl.push_back(v(0, 'h304, 0, 1, 1, 1, 0, 1, 1, 0, 0, 2));
      tbl.push_back(v(0, 'h400, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 'h404, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1));
      tbl.push_back(v(0, 'h404, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h400));
      // nested fault -> HALT, then reset
      tbl.push_back(v(0, 'h500, 2, 0, 0, 1, 0, 0, 1, 0, 0, 1));
      tbl.push_back(v(0, 'h504, 2, 1, 1, 3, 0, 0, 0, 1, 0, 2));
      tbl.push_back(v(0, 'h504, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1));
      tbl.push_back(v(0, 'h504, 0, 1, 1, 0, 0, 0, 0, 1, 0, 'h400));
      tbl.push_back(v(1, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 2));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
      // misplaced ERET with PC wrap, reset from HANDLER
      tbl.push_back(v(0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0, 3,
                      1, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 3));
      tbl.push_back(v(0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                      64'hFFFF_FFFF_FFFF_FFFC));
      tbl.push_back(v(1, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));

      chk("vector", exc_vector_o, 64'hD8);
      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].pc, tbl[i].es, tbl[i].er,
              tbl[i].irq, tbl[i].sel);
         chk($sformatf("t%0d exc", i), 64'(a_exc), 64'(tbl[i].exc));
         chk($sformatf("t%0d eret", i), 64'(a_ert), 64'(tbl[i].ert));
         chk($sformatf("t%0d hnd", i), 64'(a_hnd), 64'(tbl[i].hnd));
         chk($sformatf("t%0d halt", i), 64'(a_hlt), 64'(tbl[i].hlt));
         chk($sformatf("t%0d ack", i), 64'(a_ack), 64'(tbl[i].ack));
         chk($sformatf("t%0d rdata", i), a_rd, tbl[i].rd);
      end

      ext = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         if (!ext && ($urandom % 6 == 0)) ext = 1'b1;
         else if (ext && (m_ack || ($urandom % 20 == 0))) ext = 1'b0;
         rpc = ($urandom % 8 == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom % 16)
                                   : {32'($urandom), 32'($urandom)};
         res = ($urandom % 8 == 0) ? 4'($urandom) : 4'd0;
         step(($urandom % 60 == 0), rpc, res, ($urandom % 6 == 0),
              ext, 2'($urandom));
         chk("r exc", 64'(a_exc), 64'(e_exc));
         chk("r eret", 64'(a_ert), 64'(e_ert));
         chk("r hnd", 64'(a_hnd), 64'(e_hnd));
         chk("r halt", 64'(a_hlt), 64'(e_hlt));
         chk("r ack", 64'(a_ack), 64'(e_ack));
         chk("r rdata", a_rd, e_rd);
         chk("r err", a_err, e_err);
         chk("r excl", 64'(a_exc & a_ert), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
